lsu_mem_ctrl: RTL and testbench

- Load/store unit between the core datapath and a single-port, word-wide data bus.
- Consumes the decoded memory controls: write enable and the 5-bit access mask.
  - Mask bits [3:0] are the size lane pattern; bit 4 selects unsigned load.
- Aligns byte enables and store data onto the bus, and extracts and extends load data.
- Splits a misaligned access into two word transactions.
- Stalls the core through a request/done handshake.

---
 rtl/lsu_mem_ctrl_if.sv | 27 ++
 rtl/lsu_mem_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Word-wide single-port data bus between the load/store unit and memory.
//   o_busReq   : bus request, held until i_busAck
//   o_busWe    : 1 = write, 0 = read
//   o_busAddr  : word-aligned address
//   o_busBe    : byte lane enables (driven for reads too)
//   o_busWdata : lane-aligned write data
//   i_busAck   : transaction accepted and complete
//   i_busRdata : read data, valid with i_busAck
interface lsu_mem_ctrl_if;
  logic        o_busReq;
  logic        o_busWe;
  logic [31:0] o_busAddr;
  logic [3:0]  o_busBe;
  logic [31:0] o_busWdata;
  logic        i_busAck;
  logic [31:0] i_busRdata;

  modport master (
    output o_busReq, o_busWe, o_busAddr, o_busBe, o_busWdata,
    input  i_busAck, i_busRdata
  );

  modport slave (
    input  o_busReq, o_busWe, o_busAddr, o_busBe, o_busWdata,
    output i_busAck, i_busRdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: aligns byte lanes and store data onto a word bus,
// splits misaligned accesses into two words, and extracts/extends loads.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_req .. i_stData       : core request (held stable until o_done)
//   o_busy, o_done, o_err   : core handshake / status
//   o_ldData                : extended load result, valid with o_done
//   bus                     : word bus master port
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for i_req
// ACC0  | bus transaction for the lower (or only) word
// ACC1  | bus transaction for the upper word of a split access
// RESP  | o_done pulse; o_err / o_ldData valid
module lsu_mem_ctrl #(
  parameter int P_SPLIT_EN = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic                  i_memWrEnable,
  input  logic [4:0]            i_mask,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_stData,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_ldData,
  lsu_mem_ctrl_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        split_q, split_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  size_q, size_d;
  logic [31:0] w1_addr_q, w1_addr_d;
  logic [3:0]  w1_be_q, w1_be_d;
  logic [31:0] w1_wdata_q, w1_wdata_d;
  logic [63:0] rd_buf_q, rd_buf_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic [1:0]  off;
  logic [3:0]  size_pat;
  logic        mask_ok;
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic        split;
  logic        req_bad;
  logic        ack;

  function automatic logic [31:0] extract(logic [63:0] rd_buf, logic [1:0] sh_off,
                                          logic [3:0] size, logic uns);
    logic [31:0] sh;
    sh = 32'(rd_buf >> {sh_off, 3'b000});
    case (size)
      4'b0001: extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      4'b0011: extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // Request decode, evaluated on the live core inputs in IDLE.
  always_comb begin
    off      = i_addr[1:0];
    size_pat = i_mask[3:0];
    mask_ok  = (size_pat == 4'b0001) || (size_pat == 4'b0011) || (size_pat == 4'b1111);
    be8      = {4'b0000, size_pat} << off;
    wd64     = {32'b0, i_stData} << {off, 3'b000};
    split    = |be8[7:4];
    req_bad  = !mask_ok || (split && (P_SPLIT_EN == 0));
    // Ack only counts while a request is actually on the bus.
    ack      = bus_req_q && bus.i_busAck;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req) state_d = req_bad ? S_RESP : S_ACC0;
      S_ACC0:  if (ack)   state_d = split_q ? S_ACC1 : S_RESP;
      S_ACC1:  if (ack)   state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy         = (state_q != S_IDLE);
    o_done         = (state_q == S_RESP);
    o_err          = err_q;
    o_ldData       = ld_data_q;
    bus.o_busReq   = bus_req_q;
    bus.o_busWe    = bus_we_q;
    bus.o_busAddr  = bus_addr_q;
    bus.o_busBe    = bus_be_q;
    bus.o_busWdata = bus_wdata_q;
  end

  // Datapath next values
  always_comb begin
    we_d        = we_q;
    split_d     = split_q;
    uns_d       = uns_q;
    off_d       = off_q;
    size_d      = size_q;
    w1_addr_d   = w1_addr_q;
    w1_be_d     = w1_be_q;
    w1_wdata_d  = w1_wdata_q;
    rd_buf_d    = rd_buf_q;
    err_d       = err_q;
    ld_data_d   = ld_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          ld_data_d = 32'h0;
          err_d     = req_bad;
          if (!req_bad) begin
            we_d        = i_memWrEnable;
            split_d     = split;
            uns_d       = i_mask[4];
            off_d       = off;
            size_d      = size_pat;
            // Word 1 is captured now so the access completes even if the
            // core drops its inputs early.
            w1_addr_d   = {i_addr[31:2], 2'b00} + 32'd4;
            w1_be_d     = be8[7:4];
            w1_wdata_d  = wd64[63:32];
            bus_req_d   = 1'b1;
            bus_we_d    = i_memWrEnable;
            bus_addr_d  = {i_addr[31:2], 2'b00};
            bus_be_d    = be8[3:0];
            bus_wdata_d = wd64[31:0];
          end
        end
      end
      S_ACC0: begin
        if (ack) begin
          rd_buf_d[31:0] = bus.i_busRdata;
          if (split_q) begin
            bus_addr_d  = w1_addr_q;
            bus_be_d    = w1_be_q;
            bus_wdata_d = w1_wdata_q;
          end else begin
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
            ld_data_d = we_q ? 32'h0 : extract(rd_buf_d, off_q, size_q, uns_q);
          end
        end
      end
      S_ACC1: begin
        if (ack) begin
          rd_buf_d[63:32] = bus.i_busRdata;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          ld_data_d = we_q ? 32'h0 : extract(rd_buf_d, off_q, size_q, uns_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= 4'h0;
      w1_addr_q   <= 32'h0;
      w1_be_q     <= 4'h0;
      w1_wdata_q  <= 32'h0;
      rd_buf_q    <= 64'h0;
      err_q       <= 1'b0;
      ld_data_q   <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      we_q        <= we_d;
      split_q     <= split_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      size_q      <= size_d;
      w1_addr_q   <= w1_addr_d;
      w1_be_q     <= w1_be_d;
      w1_wdata_q  <= w1_wdata_d;
      rd_buf_q    <= rd_buf_d;
      err_q       <= err_d;
      ld_data_q   <= ld_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, req2;
  logic        we;
  logic [4:0]  mask;
  logic [31:0] addr;
  logic [31:0] st_data;

  logic        busy, done, err;
  logic [31:0] ld_data;
  logic        busy2, done2, err2;
  logic [31:0] ld_data2;

  int n_pass  = 0;
  int n_total = 0;

  lsu_mem_ctrl_if bus ();
  lsu_mem_ctrl_if bus2 ();

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.P_SPLIT_EN(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_memWrEnable(we),
    .i_mask(mask), .i_addr(addr), .i_stData(st_data),
    .o_busy(busy), .o_done(done), .o_err(err), .o_ldData(ld_data),
    .bus(bus.master)
  );

  lsu_mem_ctrl #(.P_SPLIT_EN(0)) dut_nosplit (
    .i_clk(clk), .i_reset(rst), .i_req(req2), .i_memWrEnable(we),
    .i_mask(mask), .i_addr(addr), .i_stData(st_data),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_ldData(ld_data2),
    .bus(bus2.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; mask = 5'b0;
    addr = 32'h0; st_data = 32'h0;
    bus.i_busAck = 1'b0;  bus.i_busRdata = 32'h0;
    bus2.i_busAck = 1'b0; bus2.i_busRdata = 32'h0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ld", ld_data, 32'h0);
    chk("rst_breq", 32'(bus.o_busReq), 32'd0);
    chk("rst_bwe", 32'(bus.o_busWe), 32'd0);
    chk("rst_baddr", bus.o_busAddr, 32'h0);
    chk("rst_bbe", 32'(bus.o_busBe), 32'h0);
    chk("rst_bwd", bus.o_busWdata, 32'h0);
    rst = 1'b0;
    step();

    // 1: aligned LW, ack already high while idle (must be ignored)
    bus.i_busAck = 1'b1; bus.i_busRdata = 32'hDEADBEEF;
    step();
    chk("t1_idle_ack_ignored", 32'(busy), 32'd0);
    req = 1'b1; we = 1'b0; mask = 5'b01111; addr = 32'h100;
    step();
    chk("t1_breq", 32'(bus.o_busReq), 32'd1);
    chk("t1_baddr", bus.o_busAddr, 32'h100);
    chk("t1_bbe", 32'(bus.o_busBe), 32'hF);
    chk("t1_bwe", 32'(bus.o_busWe), 32'd0);
    chk("t1_done_early", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_ld", ld_data, 32'hDEADBEEF);
    chk("t1_breq_off", 32'(bus.o_busReq), 32'd0);
    req = 1'b0;
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: LB at 0x103, signed then unsigned
    bus.i_busRdata = 32'h80112233;
    req = 1'b1; mask = 5'b00001; addr = 32'h103;
    step();
    chk("t2_bbe", 32'(bus.o_busBe), 32'h8);
    chk("t2_baddr", bus.o_busAddr, 32'h100);
    step();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_ld_sext", ld_data, 32'hFFFFFF80);
    req = 1'b0;
    step();
    req = 1'b1; mask = 5'b10001;
    step();
    step();
    chk("t2u_done", 32'(done), 32'd1);
    chk("t2_ld_zext", ld_data, 32'h00000080);
    req = 1'b0;
    step();

    // 3: misaligned SH at 0x107
    req = 1'b1; we = 1'b1; mask = 5'b00011; addr = 32'h107; st_data = 32'h0000ABCD;
    step();
    chk("t3_w0_addr", bus.o_busAddr, 32'h104);
    chk("t3_w0_be", 32'(bus.o_busBe), 32'h8);
    chk("t3_w0_wd", bus.o_busWdata, 32'hCD000000);
    chk("t3_w0_we", 32'(bus.o_busWe), 32'd1);
    step();
    chk("t3_w1_addr", bus.o_busAddr, 32'h108);
    chk("t3_w1_be", 32'(bus.o_busBe), 32'h1);
    chk("t3_w1_wd", bus.o_busWdata, 32'h000000AB);
    chk("t3_w1_req", 32'(bus.o_busReq), 32'd1);
    chk("t3_not_done", 32'(done), 32'd0);
    step();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_ld_zero", ld_data, 32'h0);
    chk("t3_err", 32'(err), 32'd0);
    req = 1'b0; bus.i_busAck = 1'b0;
    step();

    // 4: wrapping split LW at 0xFFFFFFFE, 3 wait cycles per word
    req = 1'b1; we = 1'b0; mask = 5'b01111; addr = 32'hFFFFFFFE;
    step();  // +1
    chk("t4_w0_addr", bus.o_busAddr, 32'hFFFFFFFC);
    chk("t4_w0_be", 32'(bus.o_busBe), 32'hC);
    chk("t4_w0_req", 32'(bus.o_busReq), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("t4_w0_hold_addr_c%0d", c), bus.o_busAddr, 32'hFFFFFFFC);
      chk($sformatf("t4_w0_hold_be_c%0d", c), 32'(bus.o_busBe), 32'hC);
      chk($sformatf("t4_w0_hold_req_c%0d", c), 32'(bus.o_busReq), 32'd1);
    end
    bus.i_busAck = 1'b1; bus.i_busRdata = 32'hBEEF0000;
    step();  // +5
    bus.i_busAck = 1'b0;
    chk("t4_w1_addr", bus.o_busAddr, 32'h00000000);
    chk("t4_w1_be", 32'(bus.o_busBe), 32'h3);
    for (int c = 6; c <= 8; c++) begin
      step();
      chk($sformatf("t4_w1_hold_addr_c%0d", c), bus.o_busAddr, 32'h0);
      chk($sformatf("t4_w1_hold_be_c%0d", c), 32'(bus.o_busBe), 32'h3);
      chk($sformatf("t4_w1_notdone_c%0d", c), 32'(done), 32'd0);
    end
    bus.i_busAck = 1'b1; bus.i_busRdata = 32'h0000DEAD;
    step();  // +9
    bus.i_busAck = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_ld", ld_data, 32'hDEADBEEF);
    req = 1'b0;
    step();

    // 5: invalid mask error
    req = 1'b1; mask = 5'b00111; addr = 32'h100;
    step();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_breq", 32'(bus.o_busReq), 32'd0);
    chk("t5_ld", ld_data, 32'h0);
    req = 1'b0;
    step();

    // 5b: misaligned LW with splitting disabled
    req2 = 1'b1; mask = 5'b01111; addr = 32'h101;
    step();
    chk("t5b_done", 32'(done2), 32'd1);
    chk("t5b_err", 32'(err2), 32'd1);
    chk("t5b_breq", 32'(bus2.o_busReq), 32'd0);
    chk("t5b_ld", ld_data2, 32'h0);
    req2 = 1'b0;
    step();

    // 6: reset while waiting in ACC0, then aligned SW
    req = 1'b1; we = 1'b0; mask = 5'b01111; addr = 32'h200;
    step();
    chk("t6_breq", 32'(bus.o_busReq), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_breq", 32'(bus.o_busReq), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    rst = 1'b0; req = 1'b0;
    step();
    chk("t6_no_done", 32'(done), 32'd0);
    bus.i_busAck = 1'b1;
    req = 1'b1; we = 1'b1; mask = 5'b01111; addr = 32'h204; st_data = 32'h12345678;
    step();
    chk("t6_sw_addr", bus.o_busAddr, 32'h204);
    chk("t6_sw_wd", bus.o_busWdata, 32'h12345678);
    chk("t6_sw_be", 32'(bus.o_busBe), 32'hF);
    chk("t6_sw_we", 32'(bus.o_busWe), 32'd1);
    step();
    chk("t6_sw_done", 32'(done), 32'd1);
    chk("t6_sw_err", 32'(err), 32'd0);
    chk("t6_sw_ld", ld_data, 32'h0);
    req = 1'b0; bus.i_busAck = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
